// File: rtl/vmem_slot_sched_if.sv
// Port bundle between the video fetcher, the CPU and the DRAM-side scheduler.
// The master modport is the requester side; the slave modport is vmem_slot_sched.
interface vmem_slot_sched_if;
   logic        video_go;
   logic [1:0]  video_bw;
   logic [20:0] video_addr;
   logic        video_next;
   logic        video_strobe;

   logic        cpu_req;
   logic        cpu_rnw;
   logic [20:0] cpu_addr;
   logic        cpu_next;
   logic        cpu_strobe;

   logic [20:0] dram_addr;
   logic        dram_req;
   logic        dram_rnw;
   logic        dram_rfsh;
   logic [2:0]  slot;

   modport master (
      output video_go, video_bw, video_addr, cpu_req, cpu_rnw, cpu_addr,
      input  video_next, video_strobe, cpu_next, cpu_strobe,
      input  dram_addr, dram_req, dram_rnw, dram_rfsh, slot
   );

   modport slave (
      input  video_go, video_bw, video_addr, cpu_req, cpu_rnw, cpu_addr,
      output video_next, video_strobe, cpu_next, cpu_strobe,
      output dram_addr, dram_req, dram_rnw, dram_rfsh, slot
   );
endinterface

// File: rtl/vmem_slot_sched.sv
// DRAM slot scheduler: 8-slot window arbitrating video, refresh and CPU cycles.
// Refresh generation is present only when VMEM_SCHED_RFSH_EN is defined.
module vmem_slot_sched #(
   parameter int unsigned RFSH_PERIOD  = 64,
   parameter int unsigned RFSH_MAXPEND = 3
) (
   input logic              clk,
   input logic              rst,
   input logic              cend,
   input logic              pre_cend,
   vmem_slot_sched_if.slave bus
);
   typedef enum logic [1:0] {GNT_IDLE, GNT_VIDEO, GNT_RFSH, GNT_CPU} gnt_e;

   logic [2:0]  slot_p1;
   logic [2:0]  slot_nxt;
   gnt_e        gnt_d;
   gnt_e        gnt_p0;
   logic        rfsh_due;
   logic        dram_req_p1;
   logic        dram_rnw_p1;
   logic [20:0] dram_addr_p1;
   logic        vtag_p1;
   logic        ctag_p1;

   function automatic logic slot_reserved(input logic [2:0] s, input logic [1:0] bw);
      case (bw)
         2'b00:   slot_reserved = (s == 3'd0);
         2'b01:   slot_reserved = (s[1:0] == 2'b00);
         2'b10:   slot_reserved = ~s[0];
         default: slot_reserved = 1'b1;
      endcase
   endfunction

   // Grant priority for the slot about to start; video ownership of a reserved
   // slot also keeps the CPU out of it.
   always_comb begin
      slot_nxt = slot_p1 + 3'd1;
      gnt_d    = GNT_IDLE;
      if (bus.video_go && slot_reserved(slot_nxt, bus.video_bw))
         gnt_d = GNT_VIDEO;
      else if (rfsh_due)
         gnt_d = GNT_RFSH;
      else if (bus.cpu_req)
         gnt_d = GNT_CPU;
   end

   // Stage 0: decision captured on pre_cend, consumed (and cleared) on cend
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         gnt_p0 <= GNT_IDLE;
      else if (pre_cend)
         gnt_p0 <= gnt_d;
      else if (cend)
         gnt_p0 <= GNT_IDLE;
   end

   // Stage 1: cycle started on cend, held until the next cend
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_p1      <= 3'd0;
         dram_req_p1  <= 1'b0;
         dram_rnw_p1  <= 1'b0;
         dram_addr_p1 <= 21'd0;
         vtag_p1      <= 1'b0;
         ctag_p1      <= 1'b0;
      end else if (cend) begin
         slot_p1     <= slot_nxt;
         dram_req_p1 <= (gnt_p0 == GNT_VIDEO) || (gnt_p0 == GNT_CPU);
         vtag_p1     <= (gnt_p0 == GNT_VIDEO);
         ctag_p1     <= (gnt_p0 == GNT_CPU) && bus.cpu_rnw;
         case (gnt_p0)
            GNT_VIDEO: begin
               dram_addr_p1 <= bus.video_addr;
               dram_rnw_p1  <= 1'b1;
            end
            GNT_CPU: begin
               dram_addr_p1 <= bus.cpu_addr;
               dram_rnw_p1  <= bus.cpu_rnw;
            end
            default: ;
         endcase
      end
   end

   // Handshakes are combinational on cend so they cover exactly that clk;
   // strobes report the cycle that the same cend finishes.
   assign bus.video_next   = cend && (gnt_p0 == GNT_VIDEO);
   assign bus.cpu_next     = cend && (gnt_p0 == GNT_CPU);
   assign bus.video_strobe = cend && vtag_p1;
   assign bus.cpu_strobe   = cend && ctag_p1;
   assign bus.dram_req     = dram_req_p1;
   assign bus.dram_rnw     = dram_rnw_p1;
   assign bus.dram_addr    = dram_addr_p1;
   assign bus.slot         = slot_p1;

`ifdef VMEM_SCHED_RFSH_EN
   localparam logic [7:0] DIV_LAST = 8'(RFSH_PERIOD - 1);
   localparam logic [2:0] PEND_MAX = 3'(RFSH_MAXPEND);

   logic [7:0] div_q;
   logic [2:0] pend_q;
   logic       div_wrap;
   logic       rfsh_take;
   logic       dram_rfsh_p1;

   // A coincident request and grant cancel, leaving the backlog unchanged.
   function automatic logic [2:0] pend_sat(input logic [2:0] p, input logic inc,
                                           input logic dec);
      pend_sat = p;
      if (inc && !dec && (p < PEND_MAX))
         pend_sat = p + 3'd1;
      else if (dec && !inc && (p != 3'd0))
         pend_sat = p - 3'd1;
   endfunction

   assign div_wrap  = (div_q == DIV_LAST);
   assign rfsh_take = (gnt_p0 == GNT_RFSH);
   assign rfsh_due  = (pend_q != 3'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q        <= 8'd0;
         pend_q       <= 3'd0;
         dram_rfsh_p1 <= 1'b0;
      end else if (cend) begin
         div_q        <= div_wrap ? 8'd0 : div_q + 8'd1;
         pend_q       <= pend_sat(pend_q, div_wrap, rfsh_take);
         dram_rfsh_p1 <= rfsh_take;
      end
   end

   assign bus.dram_rfsh = dram_rfsh_p1;
`else
   logic params_unused;
   assign params_unused = ^{RFSH_PERIOD, RFSH_MAXPEND};
   assign rfsh_due      = 1'b0;
   assign bus.dram_rfsh = 1'b0;
`endif

endmodule

// File: tb/tb_vmem_slot_sched.sv
// Scoreboard bench for vmem_slot_sched: grants predicted at pre_cend, checked at cend.
module tb_vmem_slot_sched;
   localparam int RP = 4;
   localparam int RM = 3;
   localparam int G_I = 0, G_V = 1, G_R = 2, G_C = 3;

   logic clk = 1'b0;
   logic rst;
   logic cend = 1'b0;
   logic pre_cend = 1'b0;

   vmem_slot_sched_if bus();

   vmem_slot_sched #(.RFSH_PERIOD(RP), .RFSH_MAXPEND(RM)) dut (
      .clk(clk), .rst(rst), .cend(cend), .pre_cend(pre_cend), .bus(bus)
   );

   always #18 clk = ~clk;

   // Free-running 4-clk DRAM cycle: pre_cend then cend
   int ph = 0;
   always @(posedge clk) begin
      #1;
      ph       = (ph + 1) % 4;
      pre_cend = (ph == 2);
      cend     = (ph == 3);
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   typedef struct packed {
      logic [1:0]  g;
      logic [20:0] addr;
      logic        rnw;
      logic [2:0]  slot;
   } rec_t;

   logic [7:0] resv [4] = '{8'h01, 8'h11, 8'h55, 8'hFF};

   rec_t        q[$];
   rec_t        r, last;
   int          m_slot, m_cnt, m_pend;
   logic [1:0]  m_pg;
   logic        m_prnw, m_rnw;
   logic [20:0] m_addr;
   bit          dram_due;
   bit          inc, dec;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_video_next",   32'(bus.video_next),   32'd0);
         chk("rst_cpu_next",     32'(bus.cpu_next),     32'd0);
         chk("rst_video_strobe", 32'(bus.video_strobe), 32'd0);
         chk("rst_cpu_strobe",   32'(bus.cpu_strobe),   32'd0);
         chk("rst_dram_req",     32'(bus.dram_req),     32'd0);
         chk("rst_dram_rnw",     32'(bus.dram_rnw),     32'd0);
         chk("rst_dram_rfsh",    32'(bus.dram_rfsh),    32'd0);
         chk("rst_dram_addr",    32'(bus.dram_addr),    32'd0);
         chk("rst_slot",         32'(bus.slot),         32'd0);
         q.delete();
         m_slot = 0; m_cnt = 0; m_pend = 0; m_pg = 2'(G_I);
         m_prnw = 1'b0; m_rnw = 1'b0; m_addr = '0; dram_due = 0;
      end else begin
         if (dram_due) begin
            chk("dram_req",  32'(bus.dram_req),  32'(last.g == G_V || last.g == G_C));
            chk("dram_rnw",  32'(bus.dram_rnw),  32'(last.rnw));
            chk("dram_rfsh", 32'(bus.dram_rfsh), 32'(last.g == G_R));
            chk("dram_addr", 32'(bus.dram_addr), 32'(last.addr));
            chk("slot",      32'(bus.slot),      32'(last.slot));
            dram_due = 0;
         end
         if (pre_cend) begin
            r.slot = 3'(m_slot + 1);
            if (bus.video_go && resv[bus.video_bw][r.slot])
               r.g = 2'(G_V);
`ifdef VMEM_SCHED_RFSH_EN
            else if (m_pend > 0)
               r.g = 2'(G_R);
`endif
            else if (bus.cpu_req)
               r.g = 2'(G_C);
            else
               r.g = 2'(G_I);
            if (r.g == G_V) begin
               r.addr = bus.video_addr; r.rnw = 1'b1;
            end else if (r.g == G_C) begin
               r.addr = bus.cpu_addr;   r.rnw = bus.cpu_rnw;
            end else begin
               r.addr = m_addr;         r.rnw = m_rnw;
            end
            q.push_back(r);
         end
         if (cend) begin
            if (q.size() > 0) r = q.pop_front();
            else begin
               r.g = 2'(G_I); r.slot = 3'(m_slot + 1); r.addr = m_addr; r.rnw = m_rnw;
            end
            chk("video_next",   32'(bus.video_next),   32'(r.g == G_V));
            chk("cpu_next",     32'(bus.cpu_next),     32'(r.g == G_C));
            chk("video_strobe", 32'(bus.video_strobe), 32'(m_pg == G_V));
            chk("cpu_strobe",   32'(bus.cpu_strobe),   32'(m_pg == G_C && m_prnw));
            m_pg = r.g; m_prnw = r.rnw; m_slot = int'(r.slot);
            m_addr = r.addr; m_rnw = r.rnw;
            m_cnt++;
            inc = (m_cnt == RP);
            if (inc) m_cnt = 0;
            dec = (r.g == G_R);
            if (inc && !dec && m_pend < RM) m_pend++;
            else if (dec && !inc) m_pend--;
            last = r;
            dram_due = 1;
         end
      end
   end

   // Advance to just after the next cend edge, reporting what that cend did.
   task automatic step(output logic gv, output logic gc, output logic vs,
                       output logic cs, output logic rf);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cend && n < 16);
      if (!cend) chk("cend_wait", 32'(cend), 32'd1);
      gv = bus.video_next;
      gc = bus.cpu_next;
      vs = bus.video_strobe;
      cs = bus.cpu_strobe;
      @(posedge clk);
      #2;
      rf = bus.dram_rfsh;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic gv, gc, vs, cs, rf;
      int   nv, nc, nr;
      rst = 1'b1;
      bus.video_go = 1'b0; bus.video_bw = 2'b00; bus.video_addr = '0;
      bus.cpu_req = 1'b0; bus.cpu_rnw = 1'b0; bus.cpu_addr = '0;
      gv = 0; gc = 0; vs = 0; cs = 0; rf = 0;
      repeat (6) @(posedge clk);
      step(gv, gc, vs, cs, rf);
      rst = 1'b0;

      // bw=1/8 with CPU hammering
      bus.video_bw = 2'b00; bus.video_go = 1'b1; bus.video_addr = 21'h00100;
      bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 21'($urandom);
      nv = 0; nc = 0;
      repeat (16) begin
         step(gv, gc, vs, cs, rf);
         nv += int'(gv); nc += int'(gc);
         if (gv) bus.video_addr = bus.video_addr + 21'd1;
         if (gc) begin bus.cpu_addr = 21'($urandom); bus.cpu_rnw = 1'($urandom); end
      end
      chk("bw0_video_next_cnt", 32'(nv), 32'd2);
`ifndef VMEM_SCHED_RFSH_EN
      chk("bw0_cpu_next_cnt", 32'(nc), 32'd14);
`endif

      // full video bandwidth locks out the CPU
      bus.video_bw = 2'b11; nv = 0; nc = 0;
      repeat (8) begin
         step(gv, gc, vs, cs, rf);
         nv += int'(gv); nc += int'(gc);
         if (gv) bus.video_addr = bus.video_addr + 21'd1;
      end
      chk("bw3_video_next_cnt", 32'(nv), 32'd8);
      chk("bw3_cpu_next_cnt",   32'(nc), 32'd0);

      // single CPU read with video off
      bus.video_bw = 2'b10; bus.video_go = 1'b0;
      bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 21'h1ABCD;
      gc = 0;
      for (int i = 0; i < 10 && !gc; i++) step(gv, gc, vs, cs, rf);
      chk("cpu_rd_granted", 32'(gc), 32'd1);
      chk("cpu_rd_dram_addr", 32'(bus.dram_addr), 32'h1ABCD);
      chk("cpu_rd_dram_rnw", 32'(bus.dram_rnw), 32'd1);
      bus.cpu_req = 1'b0;
      step(gv, gc, vs, cs, rf);
      chk("cpu_rd_strobe", 32'(cs), 32'd1);

      // periodic refresh, then saturation under full video load
      repeat (8) step(gv, gc, vs, cs, rf);
      nr = 0;
      repeat (12) begin step(gv, gc, vs, cs, rf); nr += int'(rf); end
`ifdef VMEM_SCHED_RFSH_EN
      chk("rfsh_periodic", 32'(nr), 32'd3);
`else
      chk("rfsh_periodic", 32'(nr), 32'd0);
`endif
      bus.video_bw = 2'b11; bus.video_go = 1'b1;
      repeat (40) begin
         step(gv, gc, vs, cs, rf);
         if (gv) bus.video_addr = bus.video_addr + 21'd1;
      end
      bus.video_go = 1'b0; nr = 0;
      repeat (3) begin step(gv, gc, vs, cs, rf); nr += int'(rf); end
`ifdef VMEM_SCHED_RFSH_EN
      chk("rfsh_burst", 32'(nr), 32'd3);
`else
      chk("rfsh_burst", 32'(nr), 32'd0);
`endif

      // reset right after a video grant drops the in-flight strobe
      bus.video_go = 1'b1; gv = 0;
      for (int i = 0; i < 10 && !gv; i++) step(gv, gc, vs, cs, rf);
      chk("rst_pre_video_grant", 32'(gv), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      step(gv, gc, vs, cs, rf);
      chk("rst_no_video_strobe", 32'(vs), 32'd0);

      // long CPU-only run
      bus.video_go = 1'b0; bus.cpu_req = 1'b1; nc = 0; nr = 0;
      repeat (300) begin
         step(gv, gc, vs, cs, rf);
         nc += int'(gc); nr += int'(rf);
         if (gc) begin bus.cpu_addr = 21'($urandom); bus.cpu_rnw = 1'($urandom); end
      end
`ifdef VMEM_SCHED_RFSH_EN
      chk("cpu_run_slots", 32'(nc + nr), 32'd300);
`else
      chk("cpu_run_next_cnt", 32'(nc), 32'd300);
      chk("cpu_run_rfsh_cnt", 32'(nr), 32'd0);
`endif

      // random mix, honouring the hold-until-accepted CPU protocol
      gc = 1'b1;
      repeat (80) begin
         bus.video_go   = 1'($urandom);
         bus.video_bw   = 2'($urandom);
         bus.video_addr = 21'($urandom);
         if (!bus.cpu_req || gc) begin
            bus.cpu_req  = 1'($urandom);
            bus.cpu_rnw  = 1'($urandom);
            bus.cpu_addr = 21'($urandom);
         end
         step(gv, gc, vs, cs, rf);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/vmem_slot_sched.md
Name: vmem_slot_sched

Overview:
- Schedules DRAM memory cycles between the video fetch port, the CPU port and DRAM refresh.
- Sits between the video subsystem (video_go / video_bw in, video_next / video_strobe out) and the DRAM controller.
- Uses a fixed 8-slot window to reserve guaranteed video bandwidth.
- Free slots go to refresh or CPU.

Parameters:
RFSH_PERIOD, 64, number of DRAM cycles between refresh requests (valid range 2..255)
RFSH_MAXPEND, 3, saturation limit of the pending-refresh counter (valid range 1..7)

Ports:
clk  in  1  28 MHz clock
rst  in  1  asynchronous reset, active-high
cend  in  1  one-clk pulse marking the end of the current DRAM cycle / start of the next
pre_cend  in  1  one-clk pulse on the clk before cend
video_go  in  1  video fetch active for this line
video_bw  in  2  video bandwidth: 00=1/8, 01=1/4, 10=1/2, 11=full
video_addr  in  21  video word address
video_next  out  1  video address consumed; advance address
video_strobe  out  1  video_data valid this clk
cpu_req  in  1  CPU access request, level, held until cpu_next
cpu_rnw  in  1  1=read, 0=write
cpu_addr  in  21  CPU word address
cpu_next  out  1  CPU request accepted
cpu_strobe  out  1  CPU read data valid
dram_addr  out  21  address of the cycle being started
dram_req  out  1  access cycle in progress
dram_rnw  out  1  direction of the access cycle
dram_rfsh  out  1  refresh cycle in progress
slot  out  3  current slot number

Behaviour:
- Reset (asynchronous, active-high) clears all outputs, slot, the refresh divider, the pending-refresh counter and the in-flight tag.
- Slot counter:
  - 3-bit, increments on each cend.
  - Wraps 7->0.
- Video-reserved slot set:
  - bw=00: {0}
  - bw=01: {0,4}
  - bw=10: even slots
  - bw=11: all slots
- Grant decision is evaluated at pre_cend for next slot = slot+1 (mod 8), using priority order:
  1. video, if video_go=1 and next slot is reserved
  2. refresh, if pending>0
  3. CPU, if cpu_req=1
  4. idle
- Reserved slots with video_go=0 are free for refresh and CPU.
- CPU is never granted a reserved slot while video_go=1.
- On cend, the decision is registered:
  - dram_req, dram_rnw, dram_rfsh and dram_addr update and hold for the whole cycle.
  - dram_rnw=1 for video cycles.
  - dram_addr is unchanged on idle and refresh cycles.
- video_next / cpu_next pulse for exactly the clk of that cend in which their grant takes effect.
- Data return (one DRAM cycle latency):
  - On the following cend, video_strobe is asserted if the finishing cycle was video; cpu_strobe is asserted if it was a CPU read.
  - CPU writes produce no strobe.
- Refresh:
  - The divider counts cend pulses.
  - Each time it reaches RFSH_PERIOD, pending increments, saturating at RFSH_MAXPEND.
  - A granted refresh decrements pending.
  - When increment and decrement coincide on the same cend, pending is unchanged.
- Back-to-back grants:
  - cpu_req still asserted after cpu_next is treated as a new request.
- Changes to video_bw or video_go take effect at the next pre_cend decision.
  - A cycle already started completes and strobes normally.
- Reset asserted mid-cycle:
  - Any in-flight strobe is discarded.
  - Slot restarts at 0 after release.
- Simultaneous cend and pre_cend never occur; behaviour in that case is undefined.

Optional Feature:
- Macro: VMEM_SCHED_RFSH_EN.
- Defined: refresh logic as described.
- Undefined:
  - Divider and pending counter are removed.
  - dram_rfsh is tied 0.
  - Priority becomes video then CPU.

Test Plan:
- bw=00, video_go=1, cpu_req held 1, 16 cycles:
  - video_next on slots 0 only (2 pulses).
  - cpu_next on the other 14 slots.
  - Each video_next is followed one cycle later by video_strobe.
- bw=11, video_go=1, cpu_req=1 for 8 cycles -> cpu_next never asserted; 8 video_next pulses.
- bw=10, video_go=0, cpu read to addr 0x1ABCD -> cpu_next on the next cend with dram_addr=0x1ABCD and dram_rnw=1; cpu_strobe on the following cend.
- RFSH_PERIOD=4, CPU idle, video off (macro defined) -> dram_rfsh every 4th cycle. With bw=11 held for 40 cycles, pending saturates at 3; after releasing, exactly 3 consecutive refresh cycles occur.
- Reset asserted for 1 clk immediately after a video grant -> no video_strobe; slot=0; all outputs 0.
- Macro undefined, cpu_req=1, video off for 300 cycles -> dram_rfsh stays 0; cpu_next on every cend.
